coarse_scan_detector: RTL and testbench

// Clocked, multi-channel digital successor to the analog coarse error detector.

---
 rtl/coarse_scan_detector_if.sv | 41 ++++
 rtl/coarse_scan_detector.sv | 193 +++++++++++++++++++
 tb/tb_coarse_scan_detector.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/coarse_scan_detector_if.sv
// Scan request, resolver sample buses and per-channel status
// exchanged with coarse_scan_detector.
interface coarse_scan_detector_if #(
    parameter int NCHAN = 3,
    parameter int SW    = 12,
    parameter int AW    = 15
);
    logic                scan_start;
    logic [NCHAN*SW-1:0] sin_bus;
    logic [NCHAN*SW-1:0] cos_bus;
    logic [NCHAN*AW-1:0] angle_bus;
    logic                busy;
    logic                scan_done;
    logic [NCHAN-1:0]    coarse_err;
    logic [NCHAN-1:0]    err_dir;
    logic [NCHAN-1:0]    alarm;

    modport master (
        output scan_start,
        output sin_bus,
        output cos_bus,
        output angle_bus,
        input  busy,
        input  scan_done,
        input  coarse_err,
        input  err_dir,
        input  alarm
    );

    modport slave (
        input  scan_start,
        input  sin_bus,
        input  cos_bus,
        input  angle_bus,
        output busy,
        output scan_done,
        output coarse_err,
        output err_dir,
        output alarm
    );
endinterface

// File: rtl/coarse_scan_detector.sv
// Multi-channel coarse resolver error detector: two-stage pipeline
// (multiply, then Schmitt + qualifier) walked once per scan.
module coarse_scan_detector #(
    parameter int NCHAN  = 3,
    parameter int SW     = 12,
    parameter int AW     = 15,
    parameter int THRESH = 200,
    parameter int HYST   = 40,
    parameter int QUAL   = 3
) (
    input logic                   clk,
    input logic                   rst_n,
    coarse_scan_detector_if.slave bus
);
    localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int PW = SW + 12;
    localparam int EW = SW + 2;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam logic [CW-1:0] LAST   = CW'(NCHAN - 1);
    localparam logic [EW-1:0] TH_SET = EW'(THRESH);
    localparam logic [EW-1:0] TH_CLR = EW'(THRESH - HYST);
    localparam logic [3:0]    QMAX   = 4'(QUAL);

    if (NCHAN < 1 || NCHAN > 8) begin : g_bad_nchan
        $error("NCHAN must be 1..8");
    end
    if (AW < 4) begin : g_bad_aw
        $error("AW must be at least 4");
    end
    if (HYST >= THRESH || THRESH >= (1 << (SW - 1))) begin : g_bad_th
        $error("threshold/hysteresis out of range");
    end
    if (QUAL < 1 || QUAL > 15) begin : g_bad_qual
        $error("QUAL must be 1..15");
    end

    // cos(k * 22.5 deg) in Q1.10
    function automatic logic signed [11:0] coef(input logic [3:0] k);
        logic signed [11:0] c;
        unique case (k)
            4'd0:  c =  12'sd1024;
            4'd1:  c =  12'sd946;
            4'd2:  c =  12'sd724;
            4'd3:  c =  12'sd392;
            4'd4:  c =  12'sd0;
            4'd5:  c = -12'sd392;
            4'd6:  c = -12'sd724;
            4'd7:  c = -12'sd946;
            4'd8:  c = -12'sd1024;
            4'd9:  c = -12'sd946;
            4'd10: c = -12'sd724;
            4'd11: c = -12'sd392;
            4'd12: c =  12'sd0;
            4'd13: c =  12'sd392;
            4'd14: c =  12'sd724;
            4'd15: c =  12'sd946;
        endcase
        return c;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    logic          done_q, done_d;

    logic                 v2_q;
    logic [CW-1:0]        ch2_q;
    logic signed [PW-1:0] diff_q, diff_d;

    logic [NCHAN-1:0] coarse_q, coarse_d;
    logic [NCHAN-1:0] dir_q, dir_d;
    logic [NCHAN-1:0] alarm_q, alarm_d;
    logic [3:0]       cnt_q [NCHAN];
    logic [3:0]       cnt_d [NCHAN];

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.scan_start) begin
                    state_d = SCAN;
                    ch_d    = '0;
                end
            end
            SCAN: begin
                if (ch_q == LAST) begin
                    state_d = FLUSH;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    logic signed [SW-1:0] sin_s, cos_s;
    logic [3:0]           sect;
    logic signed [11:0]   c_k, s_k;
    logic signed [PW-1:0] p_sin, p_cos;

    // Stage 1: rotate channel ch by -phi and keep the sine component
    always_comb begin
        sin_s  = bus.sin_bus[ch_q*SW +: SW];
        cos_s  = bus.cos_bus[ch_q*SW +: SW];
        sect   = bus.angle_bus[ch_q*AW + (AW - 4) +: 4];
        c_k    = coef(sect);
        s_k    = coef(sect - 4'd4);
        p_sin  = PW'(sin_s) * PW'(c_k);
        p_cos  = PW'(cos_s) * PW'(s_k);
        diff_d = p_sin - p_cos;
    end

    logic signed [EW-1:0] e;
    logic [EW-1:0]        mag;
    logic                 unused_frac;

    // Dropping the low 10 bits is the floor of diff / 1024
    assign e           = diff_q[PW-1:10];
    assign mag         = e[EW-1] ? -e : e;
    assign unused_frac = ^diff_q[9:0];

    always_comb begin
        coarse_d = coarse_q;
        dir_d    = dir_q;
        alarm_d  = alarm_q;
        for (int i = 0; i < NCHAN; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (v2_q) begin
            if (mag >= TH_SET) begin
                coarse_d[ch2_q] = 1'b1;
                dir_d[ch2_q]    = e[EW-1];
            end else if (mag < TH_CLR) begin
                coarse_d[ch2_q] = 1'b0;
            end
            if (coarse_d[ch2_q]) begin
                if (cnt_q[ch2_q] != QMAX) begin
                    cnt_d[ch2_q] = cnt_q[ch2_q] + 4'd1;
                end
            end else begin
                cnt_d[ch2_q] = 4'd0;
            end
            alarm_d[ch2_q] = (cnt_d[ch2_q] == QMAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            done_q   <= 1'b0;
            v2_q     <= 1'b0;
            ch2_q    <= '0;
            diff_q   <= '0;
            coarse_q <= '0;
            dir_q    <= '0;
            alarm_q  <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            done_q   <= done_d;
            v2_q     <= (state_q == SCAN);
            if (state_q == SCAN) begin
                ch2_q  <= ch_q;
                diff_q <= diff_d;
            end
            coarse_q <= coarse_d;
            dir_q    <= dir_d;
            alarm_q  <= alarm_d;
            for (int i = 0; i < NCHAN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.scan_done  = done_q;
    assign bus.coarse_err = coarse_q;
    assign bus.err_dir    = dir_q;
    assign bus.alarm      = alarm_q;
endmodule

// File: tb/tb_coarse_scan_detector.sv
// Directed bench for coarse_scan_detector: reference model plus
// scoreboard of expected per-scan channel status.
module tb_coarse_scan_detector;
    localparam int NCHAN  = 3;
    localparam int SW     = 12;
    localparam int AW     = 15;
    localparam int THRESH = 200;
    localparam int HYST   = 40;
    localparam int QUAL   = 3;

    typedef struct packed {
        logic [NCHAN-1:0] ce;
        logic [NCHAN-1:0] dir;
        logic [NCHAN-1:0] al;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    coarse_scan_detector_if #(.NCHAN(NCHAN), .SW(SW), .AW(AW)) bus ();

    coarse_scan_detector #(
        .NCHAN(NCHAN), .SW(SW), .AW(AW),
        .THRESH(THRESH), .HYST(HYST), .QUAL(QUAL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int CT [16] = '{1024, 946, 724, 392, 0, -392, -724, -946,
                    -1024, -946, -724, -392, 0, 392, 724, 946};

    int s_sin [NCHAN];
    int s_cos [NCHAN];
    int s_ang [NCHAN];
    int m_ce  [NCHAN];
    int m_dir [NCHAN];
    int m_cnt [NCHAN];
    obs_t exp_q [$];
    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int c, input int s, input int co, input int a);
        s_sin[c] = s;
        s_cos[c] = co;
        s_ang[c] = a;
        bus.sin_bus[c*SW +: SW]   = s[SW-1:0];
        bus.cos_bus[c*SW +: SW]   = co[SW-1:0];
        bus.angle_bus[c*AW +: AW] = a[AW-1:0];
    endtask

    function automatic int model_e(input int c);
        int k = (s_ang[c] >> (AW - 4)) & 15;
        return (s_sin[c] * CT[k] - s_cos[c] * CT[(k + 12) % 16]) >>> 10;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCHAN; i++) begin
            m_ce[i] = 0;
            m_dir[i] = 0;
            m_cnt[i] = 0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < NCHAN; i++) begin
            int e = model_e(i);
            int ae = (e < 0) ? -e : e;
            if (ae >= THRESH) begin
                m_ce[i] = 1;
                m_dir[i] = (e < 0) ? 1 : 0;
            end else if (ae < THRESH - HYST) begin
                m_ce[i] = 0;
            end
            if (m_ce[i] == 1) m_cnt[i] = (m_cnt[i] < QUAL) ? m_cnt[i] + 1 : QUAL;
            else m_cnt[i] = 0;
        end
    endfunction

    function automatic obs_t model_vec();
        obs_t r = '0;
        for (int i = 0; i < NCHAN; i++) begin
            r.ce[i] = m_ce[i][0];
            r.dir[i] = m_dir[i][0];
            r.al[i] = (m_cnt[i] == QUAL);
        end
        return r;
    endfunction

    function automatic obs_t cur_obs();
        return {bus.coarse_err, bus.err_dir, bus.alarm};
    endfunction

    // Channel i shows its new status from the negedge after edge i+2
    function automatic obs_t blend(input obs_t o, input obs_t nv, input int k);
        obs_t r = o;
        for (int i = 0; i < NCHAN; i++) begin
            if (k >= i + 2) begin
                r.ce[i] = nv.ce[i];
                r.dir[i] = nv.dir[i];
                r.al[i] = nv.al[i];
            end
        end
        return r;
    endfunction

    task automatic run_scan(input string tag, input bit repulse);
        obs_t o, nv, got;
        int ndone;
        o = model_vec();
        model_step();
        nv = model_vec();
        exp_q.push_back(nv);
        ndone = 0;
        bus.scan_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < NCHAN + 4; k++) begin
            @(negedge clk);
            bus.scan_start = (k == 0) ? repulse : 1'b0;
            check({tag, ":busy"}, bus.busy, k <= NCHAN);
            check({tag, ":done"}, bus.scan_done, k == NCHAN + 1);
            check({tag, ":chan"}, cur_obs(), blend(o, nv, k));
            if (bus.scan_done) begin
                ndone++;
                check({tag, ":sb_depth"}, exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    got = exp_q.pop_front();
                    check({tag, ":sb"}, cur_obs(), got);
                end
            end
        end
        check({tag, ":ndone"}, ndone, 1);
        check({tag, ":sb_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bus.scan_start = 1'b0;
        bus.sin_bus = '0;
        bus.cos_bus = '0;
        bus.angle_bus = '0;
        model_reset();
        drive(0, 0, 1000, 'h2000);
        drive(1, 300, 0, 'h0000);
        drive(2, 100, -2048, 'h6000);
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.scan_done, 0);
        check("rst_out", cur_obs(), model_vec());
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of a scan
        bus.scan_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.scan_start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_ce", bus.coarse_err, 3'b001);
        check("mid_dir", bus.err_dir, 3'b001);
        check("mid_busy", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.scan_done, 0);
        check("mid_rst_out", cur_obs(), model_vec());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_scan("clean", 1'b0);

        drive(0, 0, 1000, 'h0000);
        run_scan("s0_zero", 1'b0);
        check("s0_zero_ce", bus.coarse_err[0], 0);
        drive(0, 0, 1000, 'h2000);
        run_scan("s4_neg", 1'b0);
        check("s4_neg_ce", bus.coarse_err[0], 1);
        check("s4_neg_dir", bus.err_dir[0], 1);

        drive(0, 200, 0, 'h0000);
        run_scan("hyst200", 1'b0);
        check("hyst200_ce", bus.coarse_err[0], 1);
        drive(0, 170, 0, 'h0000);
        run_scan("hyst170", 1'b0);
        check("hyst170_ce", bus.coarse_err[0], 1);
        drive(0, 160, 0, 'h0000);
        run_scan("hyst160", 1'b0);
        check("hyst160_ce", bus.coarse_err[0], 1);
        drive(0, 159, 0, 'h0000);
        run_scan("hyst159", 1'b0);
        check("hyst159_ce", bus.coarse_err[0], 0);

        drive(0, 500, 0, 'h0000);
        run_scan("qual1", 1'b0);
        run_scan("qual2", 1'b0);
        check("qual2_al", bus.alarm[0], 0);
        run_scan("qual3", 1'b0);
        check("qual3_al", bus.alarm[0], 1);
        drive(0, 0, 0, 'h0000);
        run_scan("qual_clr", 1'b0);
        check("qual_clr_ce", bus.coarse_err[0], 0);
        check("qual_clr_al", bus.alarm[0], 0);

        run_scan("repulse", 1'b1);

        drive(0, -216, 0, 'h0800);
        run_scan("floor", 1'b0);
        check("floor_ce", bus.coarse_err[0], 1);
        drive(0, -2048, 2047, 'h7000);
        run_scan("ext_s14", 1'b0);
        drive(0, -2048, 2047, 'h1000);
        run_scan("ext_s2", 1'b0);
        check("ext_s2_dir", bus.err_dir[0], 1);
        drive(0, -2048, 2047, 'h5000);
        run_scan("ext_s10", 1'b0);
        check("ext_s10_dir", bus.err_dir[0], 0);
        drive(0, -2048, 2047, 'h7FFF);
        run_scan("wrap_7fff", 1'b0);
        drive(0, -2048, -2048, 'h0000);
        run_scan("wrap_0000", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
